// File: rtl/local_mean_threshold.sv
// local_mean_threshold
// Fills the threshold memory for the binarisation pass: for every pixel the
// mean of a K x K window (K = 2**WIN_BITS, border replicated) is written as
// that pixel's 8-bit threshold. Runs while global_state == 1 and raises the
// sticky finished flag after the last pixel has been written.
// Optional feature macro: MEAN_ROUND_EN (round half up instead of truncating).
module local_mean_threshold #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8,
  parameter int WIDTH       = 2**WIDTH_BITS,
  parameter int HEIGHT      = 2**HEIGHT_BITS,
  parameter int WIN_BITS    = 2
) (
  input  logic                   clock,
  input  logic                   not_reset,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oThresholdCol,
  output logic [HEIGHT_BITS-1:0] oThresholdRow,
  output logic [7:0]             oThresholdData,
  output logic                   oThresholdWren,
  input  logic [2:0]             global_state,
  output logic                   finished
);

  localparam int K      = 2**WIN_BITS;
  localparam int N      = K * K;
  localparam int HALF   = K / 2;
  localparam int SHIFT  = 2 * WIN_BITS;
  localparam int ACC_W  = 8 + SHIFT;
  localparam int SAMP_W = SHIFT;
  // Two extra bits keep both the negative and the past-the-edge coordinates
  // representable before clamping.
  localparam int CW     = WIDTH_BITS + 2;
  localparam int RW     = HEIGHT_BITS + 2;

  typedef enum logic [1:0] {IDLE, ADDR, LAST, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [WIDTH_BITS-1:0]   col_reg, col_next;
  logic [HEIGHT_BITS-1:0]  row_reg, row_next;
  logic [SAMP_W-1:0]       samp_reg, samp_next;
  logic [ACC_W-1:0]        acc_reg, acc_next;
  logic [WIDTH_BITS-1:0]   img_col_reg, img_col_next;
  logic [HEIGHT_BITS-1:0]  img_row_reg, img_row_next;
  logic [WIDTH_BITS-1:0]   thr_col_reg, thr_col_next;
  logic [HEIGHT_BITS-1:0]  thr_row_reg, thr_row_next;
  logic [7:0]              thr_data_reg, thr_data_next;
  logic                    wren_reg, wren_next;
  logic                    finished_reg, finished_next;

  logic                    run_ok;
  logic                    last_pix;
  logic                    last_samp;
  logic [ACC_W-1:0]        sum_full;
  logic [ACC_W-1:0]        sum_final;

  // Address source for the sample to be read in the following cycle
  logic                    load_addr;
  logic [WIDTH_BITS-1:0]   addr_col_src;
  logic [HEIGHT_BITS-1:0]  addr_row_src;
  logic [SAMP_W-1:0]       addr_samp_src;

  // Replicate-border clamp of pixel column plus window offset.
  function automatic logic [WIDTH_BITS-1:0] clamp_col(
    input logic [WIDTH_BITS-1:0] base,
    input logic [WIN_BITS-1:0]   off
  );
    logic signed [CW-1:0] c;
    c = $signed({2'b00, base}) + $signed(CW'(off)) - $signed(CW'(HALF));
    if (c < 0)
      clamp_col = '0;
    else if (c > $signed(CW'(WIDTH - 1)))
      clamp_col = WIDTH_BITS'(WIDTH - 1);
    else
      clamp_col = c[WIDTH_BITS-1:0];
  endfunction

  // Replicate-border clamp of pixel row plus window offset.
  function automatic logic [HEIGHT_BITS-1:0] clamp_row(
    input logic [HEIGHT_BITS-1:0] base,
    input logic [WIN_BITS-1:0]    off
  );
    logic signed [RW-1:0] r;
    r = $signed({2'b00, base}) + $signed(RW'(off)) - $signed(RW'(HALF));
    if (r < 0)
      clamp_row = '0;
    else if (r > $signed(RW'(HEIGHT - 1)))
      clamp_row = HEIGHT_BITS'(HEIGHT - 1);
    else
      clamp_row = r[HEIGHT_BITS-1:0];
  endfunction

  assign run_ok    = (global_state == 3'd1);
  assign last_pix  = (col_reg == WIDTH_BITS'(WIDTH - 1)) && (row_reg == HEIGHT_BITS'(HEIGHT - 1));
  assign last_samp = (samp_reg == SAMP_W'(N - 1));
  assign sum_full  = acc_reg + ACC_W'(iImageData);
`ifdef MEAN_ROUND_EN
  assign sum_final = sum_full + ACC_W'(N / 2);
`else
  assign sum_final = sum_full;
`endif

  // State register
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: scan window samples, then a write cycle per pixel
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (run_ok && !finished_reg) state_next = ADDR;
      ADDR: begin
        if (!run_ok)        state_next = IDLE;
        else if (last_samp) state_next = LAST;
      end
      LAST: begin
        if (!run_ok)       state_next = IDLE;
        else if (last_pix) state_next = DONE;
        else               state_next = ADDR;
      end
      default: state_next = DONE;
    endcase
  end

  // Output and datapath next values: accumulate, write threshold, advance pixel
  always_comb begin
    col_next      = col_reg;
    row_next      = row_reg;
    samp_next     = samp_reg;
    acc_next      = acc_reg;
    thr_col_next  = thr_col_reg;
    thr_row_next  = thr_row_reg;
    thr_data_next = thr_data_reg;
    wren_next     = 1'b0;
    finished_next = finished_reg;
    load_addr     = 1'b0;
    addr_col_src  = col_reg;
    addr_row_src  = row_reg;
    addr_samp_src = '0;
    case (state_reg)
      IDLE: begin
        if (run_ok && !finished_reg) begin
          samp_next = '0;
          load_addr = 1'b1;
        end
      end
      ADDR: begin
        if (!run_ok) begin
          col_next  = '0;
          row_next  = '0;
          samp_next = '0;
          acc_next  = '0;
        end else begin
          // Data arriving now belongs to the previous sample address
          if (samp_reg != '0) acc_next = sum_full;
          if (!last_samp) begin
            samp_next     = samp_reg + 1'b1;
            load_addr     = 1'b1;
            addr_samp_src = samp_reg + 1'b1;
          end
        end
      end
      LAST: begin
        if (!run_ok) begin
          col_next  = '0;
          row_next  = '0;
          samp_next = '0;
          acc_next  = '0;
        end else begin
          thr_data_next = 8'(sum_final >> SHIFT);
          thr_col_next  = col_reg;
          thr_row_next  = row_reg;
          wren_next     = 1'b1;
          acc_next      = '0;
          samp_next     = '0;
          if (last_pix) begin
            finished_next = 1'b1;
          end else begin
            load_addr = 1'b1;
            if (col_reg == WIDTH_BITS'(WIDTH - 1)) begin
              col_next     = '0;
              row_next     = row_reg + 1'b1;
              addr_col_src = '0;
              addr_row_src = row_reg + 1'b1;
            end else begin
              col_next     = col_reg + 1'b1;
              addr_col_src = col_reg + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    img_col_next = load_addr ? clamp_col(addr_col_src, addr_samp_src[WIN_BITS-1:0]) : img_col_reg;
    img_row_next = load_addr ? clamp_row(addr_row_src, addr_samp_src[SAMP_W-1:WIN_BITS]) : img_row_reg;
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      col_reg      <= '0;
      row_reg      <= '0;
      samp_reg     <= '0;
      acc_reg      <= '0;
      img_col_reg  <= '0;
      img_row_reg  <= '0;
      thr_col_reg  <= '0;
      thr_row_reg  <= '0;
      thr_data_reg <= '0;
      wren_reg     <= 1'b0;
      finished_reg <= 1'b0;
    end else begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      samp_reg     <= samp_next;
      acc_reg      <= acc_next;
      img_col_reg  <= img_col_next;
      img_row_reg  <= img_row_next;
      thr_col_reg  <= thr_col_next;
      thr_row_reg  <= thr_row_next;
      thr_data_reg <= thr_data_next;
      wren_reg     <= wren_next;
      finished_reg <= finished_next;
    end
  end

  assign oImageCol      = img_col_reg;
  assign oImageRow      = img_row_reg;
  assign oThresholdCol  = thr_col_reg;
  assign oThresholdRow  = thr_row_reg;
  assign oThresholdData = thr_data_reg;
  assign oThresholdWren = wren_reg;
  assign finished       = finished_reg;

endmodule

// File: tb/tb_local_mean_threshold.sv
// Bench for local_mean_threshold: two 16x16 instances (K=4 and K=2) run side by
// side, each with its own image RAM model and captured threshold memory.
module tb_local_mean_threshold;

  localparam int DIM = 16;

  logic       clock = 1'b0;
  logic       not_reset = 1'b0;
  logic [2:0] gs = 3'd0;

  logic [3:0] ic1, ir1, tc1, tr1, ic2, ir2, tc2, tr2;
  logic [7:0] id1, td1, id2, td2;
  logic       we1, fin1, we2, fin2;

  logic [7:0] img1 [DIM][DIM];
  logic [7:0] img2 [DIM][DIM];
  logic [7:0] thr1 [DIM][DIM];
  logic [7:0] thr2 [DIM][DIM];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  local_mean_threshold #(.WIDTH_BITS(4), .HEIGHT_BITS(4), .WIN_BITS(2)) dut1 (
    .clock(clock), .not_reset(not_reset),
    .oImageCol(ic1), .oImageRow(ir1), .iImageData(id1),
    .oThresholdCol(tc1), .oThresholdRow(tr1), .oThresholdData(td1),
    .oThresholdWren(we1), .global_state(gs), .finished(fin1));

  local_mean_threshold #(.WIDTH_BITS(4), .HEIGHT_BITS(4), .WIN_BITS(1)) dut2 (
    .clock(clock), .not_reset(not_reset),
    .oImageCol(ic2), .oImageRow(ir2), .iImageData(id2),
    .oThresholdCol(tc2), .oThresholdRow(tr2), .oThresholdData(td2),
    .oThresholdWren(we2), .global_state(gs), .finished(fin2));

  // synchronous image RAMs, 1-cycle read latency
  always @(posedge clock) begin
    id1 <= img1[ir1][ic1];
    id2 <= img2[ir2][ic2];
  end

  // write capture and protocol monitors, sampled on the falling edge
  logic clr_req = 1'b0;
  int   cyc = 0, wr1 = 0, wr2 = 0, lw1 = 0, lw2 = 0, sp_err1 = 0, sp_err2 = 0;
  int   consec_err = 0, fin_err = 0, lc1 = 0, lr1 = 0;
  logic pw1 = 1'b0, pw2 = 1'b0, pf1 = 1'b0, pf2 = 1'b0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (clr_req) begin
      wr1 <= 0; wr2 <= 0; sp_err1 <= 0; sp_err2 <= 0; fin_err <= 0;
      for (int y = 0; y < DIM; y++)
        for (int x = 0; x < DIM; x++) begin
          thr1[y][x] <= 8'd0;
          thr2[y][x] <= 8'd0;
        end
    end else begin
      if (we1) begin
        thr1[tr1][tc1] <= td1;
        wr1 <= wr1 + 1;
        lc1 <= int'(tc1);
        lr1 <= int'(tr1);
        lw1 <= cyc;
        if (wr1 > 0 && cyc - lw1 != 17) sp_err1 <= sp_err1 + 1;
      end
      if (we2) begin
        thr2[tr2][tc2] <= td2;
        wr2 <= wr2 + 1;
        lw2 <= cyc;
        if (wr2 > 0 && cyc - lw2 != 5) sp_err2 <= sp_err2 + 1;
      end
      if ((we1 && (fin1 != (tc1 == 4'd15 && tr1 == 4'd15))) ||
          (we2 && (fin2 != (tc2 == 4'd15 && tr2 == 4'd15))) ||
          (fin1 && !pf1 && !we1) || (fin2 && !pf2 && !we2))
        fin_err <= fin_err + 1;
    end
    if ((we1 && pw1) || (we2 && pw2)) consec_err <= consec_err + 1;
    pw1 <= we1; pw2 <= we2; pf1 <= fin1; pf2 <= fin2;
  end

  // reference: plain window mean with coordinate clamping
  function automatic int ref_thr(input int sel, input int x, input int y);
    int k, h, s, cx, cy;
    k = (sel == 1) ? 4 : 2;
    h = k / 2;
    s = 0;
    for (int dy = -h; dy < h; dy++)
      for (int dx = -h; dx < h; dx++) begin
        cx = x + dx; cy = y + dy;
        if (cx < 0) cx = 0;
        if (cx > DIM - 1) cx = DIM - 1;
        if (cy < 0) cy = 0;
        if (cy > DIM - 1) cy = DIM - 1;
        s += (sel == 1) ? int'(img1[cy][cx]) : int'(img2[cy][cx]);
      end
`ifdef MEAN_ROUND_EN
    return (s + (k * k) / 2) / (k * k);
`else
    return s / (k * k);
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_capture();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " dut1 outputs"}, int'({ic1, ir1, tc1, tr1, td1, we1, fin1}), 0);
    chk({tag, " dut2 outputs"}, int'({ic2, ir2, tc2, tr2, td2, we2, fin2}), 0);
  endtask

  task automatic do_reset();
    gs = 3'd0;
    not_reset = 1'b0;
    tick();
    tick();
    not_reset = 1'b1;
    tick();
  endtask

  task automatic run_full(input string tag);
    int n;
    gs = 3'd1;
    n = 0;
    while (!(fin1 && fin2) && n < 8000) begin
      tick();
      n++;
    end
    chk({tag, " finished within budget"}, int'(fin1 && fin2), 1);
    $display("run %s: %0d cycles, writes %0d/%0d", tag, n, wr1, wr2);
  endtask

  task automatic chk_memory(input string tag);
    int bad;
    bad = 0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        chk($sformatf("%s thr1(%0d,%0d)", tag, x, y), int'(thr1[y][x]), ref_thr(1, x, y));
        chk($sformatf("%s thr2(%0d,%0d)", tag, x, y), int'(thr2[y][x]), ref_thr(2, x, y));
      end
    $display("memory check %s done", tag);
  endtask

  typedef struct {
    int sel;
    int x;
    int y;
    int exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int w1, w2, n, rnd_exp;

`ifdef MEAN_ROUND_EN
    rnd_exp = 1;
`else
    rnd_exp = 0;
`endif
    vecs[0] = '{1, 0, 5, 4};
    vecs[1] = '{1, 8, 5, 120};
    vecs[2] = '{1, 15, 5, 228};
    vecs[3] = '{1, 0, 0, 4};
    vecs[4] = '{2, 0, 0, 255};
    vecs[5] = '{2, 1, 0, 127 + rnd_exp};
    vecs[6] = '{2, 0, 1, 127 + rnd_exp};
    vecs[7] = '{2, 1, 1, 63 + rnd_exp};
    vecs[8] = '{2, 2, 0, 0};

    // reset state and idle behaviour
    tick();
    chk_outs_zero("reset");
    not_reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("idle no writes dut1", wr1, 0);
    chk("idle no writes dut2", wr2, 0);

    // constant image / single bright pixel
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        img1[y][x] = 8'd100;
        img2[y][x] = (x == 0 && y == 0) ? 8'd255 : 8'd0;
      end
    clear_capture();
    run_full("const");
    chk_memory("const");
    chk("const write count dut1", wr1, 256);
    chk("const write count dut2", wr2, 256);
    chk("const spacing 17 dut1", sp_err1, 0);
    chk("const spacing 5 dut2", sp_err2, 0);
    chk("const finished on last write", fin_err, 0);

    // column ramp, table of border/interior pixels
    do_reset();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) img1[y][x] = 8'(x * 16);
    clear_capture();
    run_full("ramp");
    for (int i = 0; i < 9; i++) begin
      n = (vecs[i].sel == 1) ? int'(thr1[vecs[i].y][vecs[i].x]) : int'(thr2[vecs[i].y][vecs[i].x]);
      $display("vector %0d dut%0d pixel (%0d,%0d): got %0d", i, vecs[i].sel, vecs[i].x, vecs[i].y, n);
      chk($sformatf("vector %0d", i), n, vecs[i].exp);
    end
    chk_memory("ramp");

    // abort after 40 pixels, then restart
    do_reset();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        img1[y][x] = 8'($urandom_range(0, 255));
        img2[y][x] = 8'($urandom_range(0, 255));
      end
    clear_capture();
    gs = 3'd1;
    n = 0;
    while (wr1 < 40 && n < 2000) begin tick(); n++; end
    chk("abort reached 40 writes", int'(wr1 >= 40), 1);
    gs = 3'd0;
    w1 = wr1;
    w2 = wr2;
    for (int i = 0; i < 30; i++) tick();
    chk("abort no writes dut1", wr1, w1);
    chk("abort no writes dut2", wr2, w2);
    gs = 3'd1;
    n = 0;
    while (wr1 <= w1 && n < 100) begin tick(); n++; end
    chk("restart write seen", int'(wr1 > w1), 1);
    chk("restart col", lc1, 0);
    chk("restart row", lr1, 0);
    run_full("abort");
    chk_memory("abort");
    chk("abort total writes dut1", wr1, w1 + 256);
    chk("abort total writes dut2", wr2, w2 + 256);

    // asynchronous reset in the middle of a pixel
    do_reset();
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) begin
        img1[y][x] = 8'($urandom_range(0, 255));
        img2[y][x] = 8'($urandom_range(0, 255));
      end
    gs = 3'd1;
    for (int i = 0; i < 23; i++) tick();
    #2;
    not_reset = 1'b0;
    #1;
    chk_outs_zero("mid-pixel reset");
    tick();
    not_reset = 1'b1;
    clear_capture();
    run_full("after reset");
    chk_memory("after reset");
    chk("after reset write count dut1", wr1, 256);

    // finished is sticky and further global_state changes write nothing
    w1 = wr1;
    w2 = wr2;
    gs = 3'd2;
    for (int i = 0; i < 10; i++) tick();
    gs = 3'd1;
    for (int i = 0; i < 30; i++) tick();
    chk("done no writes dut1", wr1, w1);
    chk("done no writes dut2", wr2, w2);
    chk("done finished dut1", int'(fin1), 1);
    chk("done finished dut2", int'(fin2), 1);
    chk("wren never consecutive", consec_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
